// File: rtl/psw_pkg.sv
// Shared constants and controller state encodings for the password store.
// The controller state encodings are provided for bench-side decoding.
package psw_pkg;

   localparam int DIGIT_W = 4;
   localparam int MAX_LEN = 8;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int DATA_W  = DIGIT_W * MAX_LEN;

   typedef enum logic [2:0] {
      ST_NOOP        = 3'b000,
      ST_SET_PSW     = 3'b001,
      ST_CONFIRM_PSW = 3'b010,
      ST_CHALLENGE   = 3'b011,
      ST_SHUFFLE     = 3'b100,
      ST_LOCKED      = 3'b101,
      ST_UNLOCKED    = 3'b110
   } ctrl_state_e;

endpackage

// File: rtl/psw_store_digit_shift_reg.sv
// Digit shift register with a length counter.
// Clear has priority over shift. A shift into a full register is ignored.
module digit_shift_reg
   import psw_pkg::*;
(
   input  logic               clk_i,
   input  logic               nreset_i,
   input  logic               rst_i,
   input  logic               sl_i,
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DATA_W-1:0]  data_o,
   output logic [LEN_W-1:0]   len_o,
   output logic               full_o
);

   logic [DATA_W-1:0] data_r;
   logic [LEN_W-1:0]  len_r;
   logic              full_s;

   assign full_s = (len_r == LEN_W'(MAX_LEN));

   // Digit storage and length update; the newest digit lands in the LSBs.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         data_r <= {DATA_W{1'b0}};
         len_r  <= {LEN_W{1'b0}};
      end else if (rst_i) begin
         data_r <= {DATA_W{1'b0}};
         len_r  <= {LEN_W{1'b0}};
      end else if (sl_i && !full_s) begin
         data_r <= {data_r[DATA_W-DIGIT_W-1:0], digit_i};
         len_r  <= len_r + LEN_W'(1);
      end else begin
         data_r <= data_r;
         len_r  <= len_r;
      end
   end

   assign data_o = data_r;
   assign len_o  = len_r;
   assign full_o = full_s;

endmodule

// File: rtl/psw_store.sv
// Password store: stored password (mem) and entry buffer (buff) plus compare flags.
// Optional macro PSW_MIN_LEN_EN: same_o also requires mem length >= MIN_LEN.
module psw_store
   import psw_pkg::*;
#(
   parameter int                MASTER_LEN = 6,
   parameter logic [DATA_W-1:0] MASTER_PSW = DATA_W'(24'h000000)
`ifdef PSW_MIN_LEN_EN
   ,
   parameter int                MIN_LEN    = 4
`endif
) (
   input  logic               clk_i,
   input  logic               nreset_i,
   input  logic [DIGIT_W-1:0] digit_i,
   input  logic               mem_rst_i,
   input  logic               mem_sl_i,
   input  logic               buff_rst_i,
   input  logic               buff_sl_i,
   output logic               same_o,
   output logic               master_same_o,
   output logic               mem_limit_o,
   output logic               buff_limit_o,
   output logic [LEN_W-1:0]   mem_len_o,
   output logic [LEN_W-1:0]   buff_len_o
);

   logic [DATA_W-1:0] mem_data_s;
   logic [DATA_W-1:0] buff_data_s;
   logic [LEN_W-1:0]  mem_len_s;
   logic [LEN_W-1:0]  buff_len_s;
   logic              mem_full_s;
   logic              buff_full_s;
   logic              len_ok_s;
   logic              same_s;
   logic              master_same_s;

   digit_shift_reg u_mem (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .rst_i    (mem_rst_i),
      .sl_i     (mem_sl_i),
      .digit_i  (digit_i),
      .data_o   (mem_data_s),
      .len_o    (mem_len_s),
      .full_o   (mem_full_s)
   );

   digit_shift_reg u_buff (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .rst_i    (buff_rst_i),
      .sl_i     (buff_sl_i),
      .digit_i  (digit_i),
      .data_o   (buff_data_s),
      .len_o    (buff_len_s),
      .full_o   (buff_full_s)
   );

`ifdef PSW_MIN_LEN_EN
   assign len_ok_s = (mem_len_s >= LEN_W'(MIN_LEN));
`else
   assign len_ok_s = 1'b1;
`endif

   // Unused high digits are always zero, so whole-vector equality is exact.
   always_comb begin
      same_s        = 1'b0;
      master_same_s = 1'b0;
      if ((mem_len_s == buff_len_s) && (mem_len_s != {LEN_W{1'b0}}) &&
          (mem_data_s == buff_data_s) && len_ok_s) begin
         same_s = 1'b1;
      end else begin
         same_s = 1'b0;
      end
      if ((buff_len_s == LEN_W'(MASTER_LEN)) && (buff_data_s == MASTER_PSW)) begin
         master_same_s = 1'b1;
      end else begin
         master_same_s = 1'b0;
      end
   end

   assign same_o        = same_s;
   assign master_same_o = master_same_s;
   assign mem_limit_o   = mem_full_s;
   assign buff_limit_o  = buff_full_s;
   assign mem_len_o     = mem_len_s;
   assign buff_len_o    = buff_len_s;

endmodule

// File: tb/tb_psw_store.sv
// Scoreboard bench for psw_store: stimulus pushes expected flags, a monitor pops and compares.
module tb_psw_store;
   import psw_pkg::*;

   logic               clk;
   logic               nreset_i;
   logic [DIGIT_W-1:0] digit_i;
   logic               mem_rst_i, mem_sl_i, buff_rst_i, buff_sl_i;
   logic               same_o, master_same_o, mem_limit_o, buff_limit_o;
   logic [LEN_W-1:0]   mem_len_o, buff_len_o;

   typedef struct {
      int same;
      int master;
      int mlim;
      int blim;
      int mlen;
      int blen;
   } exp_t;

   exp_t exp_q[$];
   int   mem_m[$];
   int   buff_m[$];
   int   master_d[6] = '{1, 2, 3, 4, 5, 6};
   int   errors = 0;
   int   checks = 0;

   psw_store #(.MASTER_LEN(6), .MASTER_PSW(32'h0012_3456)) dut (
      .clk_i         (clk),
      .nreset_i      (nreset_i),
      .digit_i       (digit_i),
      .mem_rst_i     (mem_rst_i),
      .mem_sl_i      (mem_sl_i),
      .buff_rst_i    (buff_rst_i),
      .buff_sl_i     (buff_sl_i),
      .same_o        (same_o),
      .master_same_o (master_same_o),
      .mem_limit_o   (mem_limit_o),
      .buff_limit_o  (buff_limit_o),
      .mem_len_o     (mem_len_o),
      .buff_len_o    (buff_len_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a password is an ordered list of digits; compare lists.
   function automatic exp_t model_expect();
      exp_t e;
      bit eq;
      eq = (mem_m.size() == buff_m.size()) && (mem_m.size() != 0);
      if (eq) foreach (mem_m[i]) if (mem_m[i] != buff_m[i]) eq = 0;
`ifdef PSW_MIN_LEN_EN
      if (mem_m.size() < 4) eq = 0;
`endif
      e.same = eq;
      e.master = (buff_m.size() == 6);
      if (e.master != 0) foreach (master_d[i]) if (buff_m[i] != master_d[i]) e.master = 0;
      e.mlim = (mem_m.size() == MAX_LEN);
      e.blim = (buff_m.size() == MAX_LEN);
      e.mlen = mem_m.size();
      e.blen = buff_m.size();
      return e;
   endfunction

   task automatic step(input bit mr, input bit ms, input bit br, input bit bs, input int d);
      @(negedge clk);
      mem_rst_i = mr; mem_sl_i = ms; buff_rst_i = br; buff_sl_i = bs;
      digit_i = DIGIT_W'(d);
      if (mr) mem_m.delete();
      else if (ms && mem_m.size() < MAX_LEN) mem_m.push_back(d);
      if (br) buff_m.delete();
      else if (bs && buff_m.size() < MAX_LEN) buff_m.push_back(d);
      exp_q.push_back(model_expect());
   endtask

   task automatic enter_mem(input int ds[$]);
      foreach (ds[i]) step(0, 1, 0, 0, ds[i]);
   endtask

   task automatic enter_buff(input int ds[$]);
      foreach (ds[i]) step(0, 0, 0, 1, ds[i]);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_same"}, int'(same_o), 0);
      chk({tag, "_master"}, int'(master_same_o), 0);
      chk({tag, "_mlim"}, int'(mem_limit_o), 0);
      chk({tag, "_blim"}, int'(buff_limit_o), 0);
      chk({tag, "_mlen"}, int'(mem_len_o), 0);
      chk({tag, "_blen"}, int'(buff_len_o), 0);
   endtask

   // Monitor: every posedge that consumed a stimulus has one expected entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("same", int'(same_o), e.same);
            chk("master_same", int'(master_same_o), e.master);
            chk("mem_limit", int'(mem_limit_o), e.mlim);
            chk("buff_limit", int'(buff_limit_o), e.blim);
            chk("mem_len", int'(mem_len_o), e.mlen);
            chk("buff_len", int'(buff_len_o), e.blen);
         end
      end
   end

   initial begin
      int pw[$];
      int len;
      nreset_i = 1'b0;
      mem_rst_i = 1'b0; mem_sl_i = 1'b0; buff_rst_i = 1'b0; buff_sl_i = 1'b0;
      digit_i = '0;
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      nreset_i = 1'b1;

      // Matching 4-digit entry.
      enter_mem('{1, 2, 3, 4});
      enter_buff('{1, 2, 3, 4});
      // Length mismatch, then digit mismatch.
      step(0, 0, 1, 0, 0);
      enter_buff('{1, 2, 3});
      step(0, 0, 1, 0, 0);
      enter_buff('{1, 2, 3, 5});
      // Fill buff, overflow attempt, then prove contents held.
      step(0, 0, 1, 0, 0);
      enter_buff('{1, 2, 3, 4, 5, 6, 7, 8});
      step(0, 0, 0, 1, 9);
      step(1, 0, 0, 0, 0);
      enter_mem('{1, 2, 3, 4, 5, 6, 7, 8});
      step(0, 1, 0, 1, 9);
      step(0, 0, 1, 0, 0);
      // Clear wins over shift.
      step(1, 0, 0, 0, 0);
      enter_mem('{3, 3, 3});
      step(1, 1, 0, 0, 7);
      // Master password, then one digit too many; mem irrelevant.
      enter_mem('{9, 9});
      enter_buff('{1, 2, 3, 4, 5, 6});
      step(0, 0, 0, 1, 7);
      // Short matching passwords.
      step(1, 0, 1, 0, 0);
      enter_mem('{7, 7});
      enter_buff('{7, 7});
      // Simultaneous shift into both.
      step(1, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 1, i + 3);

      // Async reset mid-entry with strobes held high.
      step(0, 1, 0, 1, 4);
      @(negedge clk);
      mem_sl_i = 1'b1; buff_sl_i = 1'b1; digit_i = 4'd6;
      nreset_i = 1'b0;
      #2;
      chk_all_zero("async_rst");
      mem_m.delete();
      buff_m.delete();
      @(negedge clk);
      chk_all_zero("rst_hold");
      nreset_i = 1'b1;
      mem_sl_i = 1'b0; buff_sl_i = 1'b0;

      // Random set/confirm trials: exact copy or a mutated copy.
      for (int t = 0; t < 40; t++) begin
         step(1, 0, 1, 0, 0);
         len = $urandom_range(1, MAX_LEN);
         pw.delete();
         for (int i = 0; i < len; i++) pw.push_back($urandom_range(0, 15));
         enter_mem(pw);
         case ($urandom_range(0, 3))
            0: pw[$urandom_range(0, len - 1)] ^= $urandom_range(1, 15);
            1: pw.push_back($urandom_range(0, 15));
            2: if (len > 1) void'(pw.pop_back());
            default: ;
         endcase
         enter_buff(pw);
      end

      // Unconstrained strobe traffic.
      for (int t = 0; t < 300; t++) begin
         step($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 15));
      end
      step(0, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/psw_store.md
Name: psw_store

Overview:
- Password storage and compare datapath driven by the door-lock control unit.
- Holds the stored password (mem) and the entry buffer (buff) as two digit shift registers.
- Executes the controller's reset and shift-left strobes on both registers.
- Returns the status flags the controller consumes: same, master_same, mem_limit and buff_limit.

Parameters:
- DIGIT_W, 4, bits per keypad digit.
- MAX_LEN, 8, maximum digits held in mem and in buff.
- MASTER_LEN, 6, number of digits in the master password.
- MASTER_PSW, 24'h000000 zero-extended to MAX_LEN*DIGIT_W bits, master password digits, right-aligned, last-entered digit in the LSBs.
- MIN_LEN, 4, minimum stored length; used only when PSW_MIN_LEN_EN is defined.

Ports:
- clk_i  in  1  system clock; all state updates on posedge.
- nreset_i  in  1  asynchronous active-low reset.
- digit_i  in  DIGIT_W  keypad digit; sampled on the posedge where a shift strobe is high.
- mem_rst_i  in  1  clear mem and mem length.
- mem_sl_i  in  1  shift digit_i into mem.
- buff_rst_i  in  1  clear buff and buff length.
- buff_sl_i  in  1  shift digit_i into buff.
- same_o  out  1  buff equals mem.
- master_same_o  out  1  buff equals the master password.
- mem_limit_o  out  1  mem is full.
- buff_limit_o  out  1  buff is full.
- mem_len_o  out  LEN_W  digits currently in mem.
- buff_len_o  out  LEN_W  digits currently in buff.

Behaviour:
- Clocking and reset
  - One clock, clk_i. Reset is asynchronous, active-low (nreset_i).
  - While nreset_i=0: both data vectors = 0, both lengths = 0.
  - Resulting outputs: same_o=0, master_same_o=0 (1 only if MASTER_LEN=0), mem_limit_o=0, buff_limit_o=0.
  - Reset mid-operation clears everything immediately, regardless of strobes.
- Strobe timing
  - Controller drives strobes from negedge-clocked state.
  - This block samples strobes and digit_i on posedge, giving half a cycle of setup.
  - Each strobe is level-sampled. A strobe held for N posedges performs N operations; the controller guarantees 1-cycle pulses.
- Per-register update (mem and buff identical, independent)
  - rst high: data <= 0, len <= 0. rst has priority over sl when both are high.
  - sl high, rst low, len < MAX_LEN: data <= {data[MAX_LEN*DIGIT_W-DIGIT_W-1:0], digit_i}, len <= len+1.
  - sl high, len == MAX_LEN: no change. No wrap and no overwrite of the oldest digit; the controller resets on limit.
  - Neither strobe: hold.
- Simultaneous strobes
  - mem_sl_i and buff_sl_i together: both registers shift in the same digit_i.
  - Strobes to one register never affect the other.
- Status outputs
  - All status outputs are combinational from registers only, with no input-to-output paths.
  - Each is valid from the posedge after the update, before the controller's next negedge.
  - mem_limit_o = (mem_len == MAX_LEN). buff_limit_o likewise.
  - same_o = (mem_len == buff_len) && (mem_len != 0) && (mem_data == buff_data).
    - Unused high digits are always 0, so a full-vector compare is exact.
    - Empty equals empty gives same_o=0.
  - master_same_o = (buff_len == MASTER_LEN) && (buff_data == MASTER_PSW).
- Width
  - LEN_W = $clog2(MAX_LEN+1).
  - Length counters never exceed MAX_LEN.

Optional Feature:
- Macro: PSW_MIN_LEN_EN.
- Defined: same_o additionally requires mem_len >= MIN_LEN, so a too-short stored password never matches and confirm fails back to set-password.
- Not defined: no minimum; any non-zero matching length gives same_o=1. MIN_LEN is unused.

Decomposition:
- Shared package psw_pkg
  - Constants DIGIT_W, MAX_LEN and LEN_W.
  - Controller state encodings (noop 000, set_psw 001, confirm_psw 010, challenge 011, shuffle 100, locked 101, unlocked 110), for bench decoding.
- Sub-module digit_shift_reg
  - Ports: clk_i, nreset_i, rst_i, sl_i, digit_i, data_o, len_o, full_o.
  - Instantiated twice (mem, buff).
  - Compare logic and the optional feature stay in psw_store.

Test Plan:
- Reset, then mem_sl with digits 1,2,3,4, then buff_sl with 1,2,3,4 -> mem_len_o=4, buff_len_o=4, same_o=1, limits 0.
- Same mem contents, buff entered as 1,2,3 -> same_o=0 (length mismatch). After buff_rst, enter 1,2,3,5 -> same_o=0.
- Shift 8 digits into buff -> buff_limit_o=1 after the 8th posedge. A 9th buff_sl with digit 9 -> data and len unchanged. buff_rst -> len 0, limit 0.
- mem_rst_i and mem_sl_i high on the same edge with mem_len=3 -> mem_len_o=0, data 0.
- buff entered as the MASTER_PSW digits (with MASTER_PSW set to 24'h123456, digits 1,2,3,4,5,6) -> master_same_o=1. One extra digit -> 0. Independent of mem contents.
- With PSW_MIN_LEN_EN defined and MIN_LEN=4: mem and buff both 7,7 -> same_o=0. Without the macro -> same_o=1. Assert nreset_i low mid-entry -> all outputs 0 asynchronously.
